// File: rtl/clk_reset_gen.sv
// Divided-clock generator with reset sequencing, per-channel enable and single-step control.
// Each channel emits a 50% duty clock of period 2*(div_half+1) source cycles and a rise strobe.
module clk_reset_gen #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned DIV_W       = 24,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic                   CLK_16mhz,
    input  logic                   resetn,
    input  logic [N_CH*DIV_W-1:0]  div_half,
    input  logic [N_CH-1:0]        ch_en,
    input  logic [N_CH-1:0]        step_mode,
    input  logic [N_CH-1:0]        step,
    output logic [N_CH-1:0]        clk_out,
    output logic [N_CH-1:0]        rise_stb,
    output logic                   sys_resetn,
    output logic [N_CH-1:0]        ch_resetn
);

    // One extra bit so div_half all-ones yields H = 2^DIV_W without wrapping.
    localparam int unsigned CntW = DIV_W + 1;

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [N_CH-1:0]        step_q, step_pulse;
    state_e                 state_q [N_CH];
    state_e                 state_d [N_CH];
    logic [CntW-1:0]        cnt_q   [N_CH];
    logic [CntW-1:0]        cnt_d   [N_CH];
    logic [CntW-1:0]        h_q     [N_CH];
    logic [CntW-1:0]        h_d     [N_CH];
    logic [CntW-1:0]        h_new   [N_CH];
    logic [N_CH-1:0]        clk_q, clk_d, rise_q, rise_d, crst_q, crst_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign sys_resetn = sync_q[SYNC_STAGES-1];
    assign step_pulse = step & ~step_q;

    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            h_new[ch] = {1'b0, div_half[ch*DIV_W +: DIV_W]} + CntW'(1);
        end
    end

    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            h_d[ch]     = h_q[ch];
            clk_d[ch]   = clk_q[ch];
            rise_d[ch]  = 1'b0;
            crst_d[ch]  = crst_q[ch];
            if (!sys_resetn) begin
                state_d[ch] = StIdle;
                cnt_d[ch]   = '0;
                clk_d[ch]   = 1'b0;
            end else begin
                case (state_q[ch])
                    StIdle: begin
                        if (ch_en[ch] && (!step_mode[ch] || step_pulse[ch])) begin
                            state_d[ch] = StHigh;
                            h_d[ch]     = h_new[ch];
                            cnt_d[ch]   = '0;
                            clk_d[ch]   = 1'b1;
                            rise_d[ch]  = 1'b1;
                        end
                    end
                    StHigh: begin
                        if (cnt_q[ch] == h_q[ch] - CntW'(1)) begin
                            state_d[ch] = StLow;
                            cnt_d[ch]   = '0;
                            clk_d[ch]   = 1'b0;
                            crst_d[ch]  = 1'b1;
                        end else begin
                            cnt_d[ch] = cnt_q[ch] + CntW'(1);
                        end
                    end
                    StLow: begin
                        if (cnt_q[ch] == h_q[ch] - CntW'(1)) begin
                            cnt_d[ch] = '0;
                            // Enable/step-mode changes only take effect at a period boundary.
                            if (ch_en[ch] && !step_mode[ch]) begin
                                state_d[ch] = StHigh;
                                h_d[ch]     = h_new[ch];
                                clk_d[ch]   = 1'b1;
                                rise_d[ch]  = 1'b1;
                            end else begin
                                state_d[ch] = StIdle;
                                clk_d[ch]   = 1'b0;
                            end
                        end else begin
                            cnt_d[ch] = cnt_q[ch] + CntW'(1);
                        end
                    end
                    default: begin
                        state_d[ch] = StIdle;
                        cnt_d[ch]   = '0;
                        clk_d[ch]   = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK_16mhz or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            step_q <= '0;
            clk_q  <= '0;
            rise_q <= '0;
            crst_q <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                state_q[ch] <= StIdle;
                cnt_q[ch]   <= '0;
                h_q[ch]     <= '0;
            end
        end else begin
            sync_q <= sync_d;
            step_q <= step;
            clk_q  <= clk_d;
            rise_q <= rise_d;
            crst_q <= crst_d;
            for (int ch = 0; ch < N_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
                h_q[ch]     <= h_d[ch];
            end
        end
    end

    assign clk_out   = clk_q;
    assign rise_stb  = rise_q;
    assign ch_resetn = crst_q;

endmodule

// File: doc/clk_reset_gen.md
Name: clk_reset_gen

Overview:
- Parametrised clock-enable/divided-clock and reset-sequencing block, driven by the board oscillator.
- Generates N_CH independently programmable divided clocks, each with a one-cycle rise strobe.
- Provides a multi-stage synchronised system reset and a per-channel reset released cleanly against each divided clock.
- Adds per-channel enable and single-step (debug) mode so the CPU clock can be halted or advanced one period at a time.

Parameters:
- N_CH, 2: number of divided-clock channels.
- DIV_W, 24: width of each half-period control field.
- SYNC_STAGES, 3: reset synchroniser depth, minimum 2.

Ports:
- CLK_16mhz  input  1  source clock; every flop in the block runs on its rising edge.
- resetn  input  1  asynchronous active-low reset, typically driven by the PLL lock output.
- div_half  input  N_CH*DIV_W  per-channel half-period H = div_half[ch]+1 source cycles; channel ch occupies bits [ch*DIV_W +: DIV_W].
- ch_en  input  N_CH  per-channel run enable.
- step_mode  input  N_CH  1 = channel advances only on a step request.
- step  input  N_CH  step request, level, synchronous to CLK_16mhz, already debounced.
- clk_out  output  N_CH  registered divided clock.
- rise_stb  output  N_CH  one-cycle pulse in the cycle clk_out goes 0->1.
- sys_resetn  output  1  synchronised active-low reset.
- ch_resetn  output  N_CH  per-channel active-low reset aligned to clk_out.

Behaviour:
- Reset is one clock, asynchronous, active-low.
- resetn=0 asynchronously clears:
  - the synchroniser chain;
  - all channel state and the step edge-detect registers.
- Reset values: clk_out=0, rise_stb=0, sys_resetn=0, ch_resetn=0.
- sys_resetn is a SYNC_STAGES-deep shift of constant 1. It rises on the SYNC_STAGES-th rising edge after resetn deasserts.
- Reset asserted mid-operation: all outputs go to reset values immediately, without waiting for a clock edge.
- While sys_resetn=0, every channel is held in IDLE with its counter at 0.
- Step edge detect: step_pulse[ch] = step[ch] & !step_q[ch], where step_q is step registered once. Holding step high yields one pulse only.
- Per-channel FSM, states IDLE, HIGH, LOW:
  - IDLE: clk_out=0. The channel moves to HIGH when sys_resetn & ch_en & (!step_mode | step_pulse). On that edge it latches H from div_half into h_reg, clears cnt, and sets clk_out=1 and rise_stb=1.
  - HIGH: cnt increments each cycle. When cnt==h_reg-1: clk_out<=0, cnt<=0, next state LOW.
  - LOW: cnt increments each cycle. When cnt==h_reg-1:
    - if ch_en & !step_mode: go to HIGH, relatch h_reg, clk_out<=1, rise_stb<=1;
    - otherwise go to IDLE.
- Resulting waveform:
  - free-run period is 2H cycles at 50% duty;
  - H=1 (div_half=0) gives divide-by-2;
  - div_half all-ones gives H=2^DIV_W, so the counter is DIV_W+1 bits wide.
- div_half changes take effect only at the next relatch (start of a HIGH phase). A period in progress is never shortened or stretched, so no glitch is possible.
- ch_en deasserted, or step_mode set, mid-period: the current period completes, then the channel enters IDLE with clk_out low. No runt pulses.
- step_pulse in HIGH or LOW is ignored and not queued.
- Step mode: each accepted step_pulse produces exactly one H-high/H-low period.
- ch_resetn[ch] goes to 1 on the first HIGH->LOW transition of that channel after sys_resetn=1. It then stays 1 until resetn asserts.
- ch_resetn ignores ch_en and step_mode once released.
- Channels are fully independent; simultaneous events on different channels do not interact.

Test Plan:
- Reset release, all defaults (SYNC_STAGES=3, N_CH=2, DIV_W=24): resetn 0->1 -> sys_resetn rises on the 3rd rising edge. Pulse resetn low mid-run -> sys_resetn, clk_out and ch_resetn drop at once, without waiting for a clock edge.
- Free run ch0 with div_half=3 (H=4), ch_en=1 -> clk_out period 8 cycles, 4 high/4 low, rise_stb once per 8 cycles. ch_resetn[0] rises at the first falling edge of clk_out[0].
- div_half=0 -> period 2. div_half=all-ones -> HIGH lasts 16,777,216 cycles. Change 3->9 mid-HIGH -> current period stays 8 cycles and the next period is 20.
- Free run with H=4, clear ch_en at cycle 2 of HIGH -> clk_out finishes 4 high/4 low, then stays 0. Re-set ch_en -> the next edge raises clk_out with rise_stb.
- step_mode=1, H=2 -> no clocks. One step held 10 cycles -> exactly one period (2 high/2 low). Step pulses during that period -> ignored.
- Two channels with H=1 and H=5 running concurrently -> periods 2 and 10, independent. Disabling ch1 leaves ch0 unaffected.
